load_store_controller: RTL and testbench

LOAD_STORE_CONTROLLER -- requirements
Module: load_store_controller

---
 rtl/load_store_controller.sv | 305 ++++++++++++++++++++++++++++++
 tb/tb_load_store_controller.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/load_store_controller.sv
// -----------------------------------------------------------------------------
// load_store_controller
//
// Purpose:
//   Accepts one load/store request at a time from the core and performs it on a
//   word-oriented memory bus. Byte and half-word accesses are steered to the
//   correct byte lanes. Load results are extracted from the lanes and then
//   sign- or zero-extended. Misaligned accesses are either split into two bus
//   transfers or rejected with a fault flag.
//
// Build option:
//   LSU_MISALIGNED_SPLIT_EN
//     defined   - misaligned accesses become two word transfers (FIRST, SECOND)
//     undefined - misaligned requests go straight to DONE with no bus request
//                 and report lsu_misaligned = 1
//
// Ports:
//   clk, rst_n        clock (rising edge), asynchronous active-low reset
//   lsu_valid/ready   core request handshake; ready only while idle
//   lsu_we            1 = store, 0 = load
//   lsu_addr          byte address
//   lsu_width         BYTE / HALF / WORD
//   lsu_signed        sign-extend loaded data
//   lsu_wdata         LSB-aligned store data
//   lsu_done          one-cycle completion pulse
//   lsu_rdata         extended load result (0 for stores), held until next accept
//   lsu_misaligned    fault flag, held until next accept
//   mem_req/gnt       bus request held until granted; rdata valid with gnt
//   mem_addr          word-aligned bus address
//   mem_we/be/wdata   bus write enable, byte enables, lane-positioned data
//   mem_rdata         bus read data
// -----------------------------------------------------------------------------
package load_store_controller_pkg;
    typedef enum logic [1:0] {
        MEM_BYTE = 2'd0,
        MEM_HALF = 2'd1,
        MEM_WORD = 2'd2
    } memory_access_width_t;
endpackage

module load_store_controller
    import load_store_controller_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 lsu_valid,
    output logic                 lsu_ready,
    input  logic                 lsu_we,
    input  logic [31:0]          lsu_addr,
    input  memory_access_width_t lsu_width,
    input  logic                 lsu_signed,
    input  logic [31:0]          lsu_wdata,
    output logic                 lsu_done,
    output logic [31:0]          lsu_rdata,
    output logic                 lsu_misaligned,
    output logic                 mem_req,
    input  logic                 mem_gnt,
    output logic [31:0]          mem_addr,
    output logic                 mem_we,
    output logic [3:0]           mem_be,
    output logic [31:0]          mem_wdata,
    input  logic [31:0]          mem_rdata
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_FIRST  = 2'd1;
    localparam logic [1:0] ST_SECOND = 2'd2;
    localparam logic [1:0] ST_DONE   = 2'd3;

    // Byte-enable pattern of an access before it is shifted to its offset.
    function automatic logic [3:0] be_pattern(input memory_access_width_t width);
        logic [3:0] pat;
        case (width)
            MEM_BYTE: pat = 4'b0001;
            MEM_HALF: pat = 4'b0011;
            MEM_WORD: pat = 4'b1111;
            default:  pat = 4'b1111;
        endcase
        return pat;
    endfunction

    // An access is misaligned when it crosses a word boundary.
    function automatic logic is_misaligned(input memory_access_width_t width,
                                           input logic [1:0]           off);
        logic mis;
        case (width)
            MEM_BYTE: mis = 1'b0;
            MEM_HALF: mis = (off == 2'd3);
            MEM_WORD: mis = (off != 2'd0);
            default:  mis = (off != 2'd0);
        endcase
        return mis;
    endfunction

    // Sign- or zero-extend the LSB-aligned raw load data to 32 bits.
    function automatic logic [31:0] extend_load(input logic [31:0]          raw,
                                                input memory_access_width_t width,
                                                input logic                 sgn);
        logic [31:0] ext;
        case (width)
            MEM_BYTE: ext = {{24{sgn & raw[7]}}, raw[7:0]};
            MEM_HALF: ext = {{16{sgn & raw[15]}}, raw[15:0]};
            MEM_WORD: ext = raw;
            default:  ext = raw;
        endcase
        return ext;
    endfunction

    // State and registered outputs
    logic [1:0]  state_r;
    logic [1:0]  next_state_s;
    logic        lsu_ready_r;
    logic        lsu_done_r;
    logic [31:0] lsu_rdata_r;
    logic        lsu_misaligned_r;
    logic        mem_req_r;
    logic [31:0] mem_addr_r;
    logic        mem_we_r;
    logic [3:0]  mem_be_r;
    logic [31:0] mem_wdata_r;

    // Request fields latched on accept
    logic                 we_r;
    memory_access_width_t width_r;
    logic                 signed_r;
    logic [1:0]           off_r;
    logic                 split_r;
    logic [31:0]          second_addr_r;
    logic [3:0]           be_hi_r;
    logic [31:0]          wdata_hi_r;
    logic [31:0]          first_rdata_r;

    // Combinational views of the incoming request and of returned data
    logic        accept_s;
    logic [1:0]  req_off_s;
    logic        req_mis_s;
    logic        req_split_s;
    logic        req_fault_s;
    logic [7:0]  req_be_full_s;
    logic [63:0] req_wdata_full_s;
    logic [31:0] aligned_raw_s;
    logic [31:0] split_raw_s;

    assign lsu_ready      = lsu_ready_r;
    assign lsu_done       = lsu_done_r;
    assign lsu_rdata      = lsu_rdata_r;
    assign lsu_misaligned = lsu_misaligned_r;
    assign mem_req        = mem_req_r;
    assign mem_addr       = mem_addr_r;
    assign mem_we         = mem_we_r;
    assign mem_be         = mem_be_r;
    assign mem_wdata      = mem_wdata_r;

    // Decode the incoming request: lanes, store data placement, split/fault.
    always_comb begin
        accept_s  = lsu_valid & lsu_ready_r;
        req_off_s = lsu_addr[1:0];
        req_mis_s = is_misaligned(lsu_width, req_off_s);
        // Upper nibble / upper word hold the lanes that spill into the next word.
        req_be_full_s    = {4'b0000, be_pattern(lsu_width)} << req_off_s;
        req_wdata_full_s = {32'd0, lsu_wdata} << {req_off_s, 3'b000};
`ifdef LSU_MISALIGNED_SPLIT_EN
        req_split_s = req_mis_s;
        req_fault_s = 1'b0;
`else
        req_split_s = 1'b0;
        req_fault_s = req_mis_s;
`endif
    end

    // Extract raw load data from the bus word(s), LSB-aligned.
    always_comb begin
        aligned_raw_s = mem_rdata >> {off_r, 3'b000};
        // Second word supplies the high bytes, first word the low bytes.
        split_raw_s   = 32'({mem_rdata, first_rdata_r} >> {off_r, 3'b000});
    end

    // Next-state logic of the transfer sequencer.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    if (req_fault_s) begin
                        next_state_s = ST_DONE;
                    end else begin
                        next_state_s = ST_FIRST;
                    end
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_FIRST: begin
                if (mem_gnt) begin
                    if (split_r) begin
                        next_state_s = ST_SECOND;
                    end else begin
                        next_state_s = ST_DONE;
                    end
                end else begin
                    next_state_s = ST_FIRST;
                end
            end
            ST_SECOND: begin
                if (mem_gnt) begin
                    next_state_s = ST_DONE;
                end else begin
                    next_state_s = ST_SECOND;
                end
            end
            ST_DONE: begin
                next_state_s = ST_IDLE;
            end
            default: begin
                next_state_s = ST_IDLE;
            end
        endcase
    end

    // State register, request latches, bus outputs and core result registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r          <= ST_IDLE;
            lsu_ready_r      <= 1'b1;
            lsu_done_r       <= 1'b0;
            lsu_rdata_r      <= 32'd0;
            lsu_misaligned_r <= 1'b0;
            mem_req_r        <= 1'b0;
            mem_addr_r       <= 32'd0;
            mem_we_r         <= 1'b0;
            mem_be_r         <= 4'd0;
            mem_wdata_r      <= 32'd0;
            we_r             <= 1'b0;
            width_r          <= MEM_BYTE;
            signed_r         <= 1'b0;
            off_r            <= 2'd0;
            split_r          <= 1'b0;
            second_addr_r    <= 32'd0;
            be_hi_r          <= 4'd0;
            wdata_hi_r       <= 32'd0;
            first_rdata_r    <= 32'd0;
        end else begin
            state_r     <= next_state_s;
            lsu_ready_r <= (next_state_s == ST_IDLE);
            lsu_done_r  <= (next_state_s == ST_DONE);
            mem_req_r   <= (next_state_s == ST_FIRST) || (next_state_s == ST_SECOND);

            case (state_r)
                ST_IDLE: begin
                    if (accept_s) begin
                        we_r             <= lsu_we;
                        width_r          <= lsu_width;
                        signed_r         <= lsu_signed;
                        off_r            <= req_off_s;
                        split_r          <= req_split_s;
                        // Wraps from 0xFFFFFFFC to 0x00000000 by natural overflow.
                        second_addr_r    <= {lsu_addr[31:2], 2'b00} + 32'd4;
                        be_hi_r          <= req_be_full_s[7:4];
                        wdata_hi_r       <= req_wdata_full_s[63:32];
                        lsu_rdata_r      <= 32'd0;
                        lsu_misaligned_r <= req_fault_s;
                        if (!req_fault_s) begin
                            mem_addr_r  <= {lsu_addr[31:2], 2'b00};
                            mem_we_r    <= lsu_we;
                            mem_be_r    <= req_be_full_s[3:0];
                            mem_wdata_r <= req_wdata_full_s[31:0];
                        end
                    end
                end
                ST_FIRST: begin
                    if (mem_gnt) begin
                        if (split_r) begin
                            first_rdata_r <= mem_rdata;
                            mem_addr_r    <= second_addr_r;
                            mem_be_r      <= be_hi_r;
                            mem_wdata_r   <= wdata_hi_r;
                        end else begin
                            mem_we_r <= 1'b0;
                            mem_be_r <= 4'd0;
                            if (!we_r) begin
                                lsu_rdata_r <= extend_load(aligned_raw_s, width_r, signed_r);
                            end
                        end
                    end
                end
                ST_SECOND: begin
                    if (mem_gnt) begin
                        mem_we_r <= 1'b0;
                        mem_be_r <= 4'd0;
                        if (!we_r) begin
                            lsu_rdata_r <= extend_load(split_raw_s, width_r, signed_r);
                        end
                    end
                end
                ST_DONE: begin
                    lsu_done_r <= 1'b0;
                end
                default: begin
                    mem_be_r <= 4'd0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_controller.sv
// -----------------------------------------------------------------------------
// tb_load_store_controller
//
// Directed testbench for load_store_controller. Each task drives one scenario
// and compares DUT outputs, sampled on the falling clock edge, against
// hand-computed values. Split-access scenarios pick their expectations from
// LSU_MISALIGNED_SPLIT_EN.
// -----------------------------------------------------------------------------
module tb_load_store_controller;
    import load_store_controller_pkg::*;

    logic                 clk;
    logic                 rst_n;
    logic                 lsu_valid;
    logic                 lsu_ready;
    logic                 lsu_we;
    logic [31:0]          lsu_addr;
    memory_access_width_t lsu_width;
    logic                 lsu_signed;
    logic [31:0]          lsu_wdata;
    logic                 lsu_done;
    logic [31:0]          lsu_rdata;
    logic                 lsu_misaligned;
    logic                 mem_req;
    logic                 mem_gnt;
    logic [31:0]          mem_addr;
    logic                 mem_we;
    logic [3:0]           mem_be;
    logic [31:0]          mem_wdata;
    logic [31:0]          mem_rdata;

    int checks;
    int failures;

    load_store_controller dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .lsu_valid      (lsu_valid),
        .lsu_ready      (lsu_ready),
        .lsu_we         (lsu_we),
        .lsu_addr       (lsu_addr),
        .lsu_width      (lsu_width),
        .lsu_signed     (lsu_signed),
        .lsu_wdata      (lsu_wdata),
        .lsu_done       (lsu_done),
        .lsu_rdata      (lsu_rdata),
        .lsu_misaligned (lsu_misaligned),
        .mem_req        (mem_req),
        .mem_gnt        (mem_gnt),
        .mem_addr       (mem_addr),
        .mem_we         (mem_we),
        .mem_be         (mem_be),
        .mem_wdata      (mem_wdata),
        .mem_rdata      (mem_rdata)
    );

    // 10-unit clock period
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Present one request for exactly one accept edge; returns just after it.
    task automatic send(input logic we, input logic [31:0] addr,
                        input memory_access_width_t w, input logic sgn,
                        input logic [31:0] wd);
        @(negedge clk);
        lsu_valid  = 1'b1;
        lsu_we     = we;
        lsu_addr   = addr;
        lsu_width  = w;
        lsu_signed = sgn;
        lsu_wdata  = wd;
        @(posedge clk);
        #1 lsu_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if (mem_req !== 1'b0) begin failures++; $display("FAIL rst_mem_req got=%b exp=0", mem_req); end
        checks++; if (lsu_done !== 1'b0) begin failures++; $display("FAIL rst_done got=%b exp=0", lsu_done); end
        checks++; if (lsu_misaligned !== 1'b0) begin failures++; $display("FAIL rst_mis got=%b exp=0", lsu_misaligned); end
        checks++; if (lsu_rdata !== 32'h0) begin failures++; $display("FAIL rst_rdata got=%h exp=0", lsu_rdata); end
        checks++; if (mem_be !== 4'h0) begin failures++; $display("FAIL rst_be got=%b exp=0000", mem_be); end
        checks++; if (mem_we !== 1'b0) begin failures++; $display("FAIL rst_we got=%b exp=0", mem_we); end
        checks++; if (mem_addr !== 32'h0) begin failures++; $display("FAIL rst_addr got=%h exp=0", mem_addr); end
        checks++; if (mem_wdata !== 32'h0) begin failures++; $display("FAIL rst_wdata got=%h exp=0", mem_wdata); end
        rst_n = 1'b1;
        @(negedge clk);
        checks++; if (lsu_ready !== 1'b1) begin failures++; $display("FAIL rst_ready got=%b exp=1", lsu_ready); end
    endtask

    task automatic test_load_byte();
        send(1'b0, 32'h0000_0103, MEM_BYTE, 1'b1, 32'h0);
        @(negedge clk);   // cycle 1
        checks++; if (mem_req !== 1'b1) begin failures++; $display("FAIL lb_req got=%b exp=1", mem_req); end
        checks++; if (mem_addr !== 32'h0000_0100) begin failures++; $display("FAIL lb_addr got=%h exp=00000100", mem_addr); end
        checks++; if (mem_be !== 4'b1000) begin failures++; $display("FAIL lb_be got=%b exp=1000", mem_be); end
        checks++; if (mem_we !== 1'b0) begin failures++; $display("FAIL lb_we got=%b exp=0", mem_we); end
        checks++; if (lsu_ready !== 1'b0) begin failures++; $display("FAIL lb_ready_busy got=%b exp=0", lsu_ready); end
        mem_gnt   = 1'b1;
        mem_rdata = 32'h80FF_FFFF;
        @(negedge clk);   // cycle 2
        mem_gnt = 1'b0;
        checks++; if (lsu_done !== 1'b1) begin failures++; $display("FAIL lb_done got=%b exp=1", lsu_done); end
        checks++; if (lsu_rdata !== 32'hFFFF_FF80) begin failures++; $display("FAIL lb_rdata got=%h exp=ffffff80", lsu_rdata); end
        checks++; if (lsu_misaligned !== 1'b0) begin failures++; $display("FAIL lb_mis got=%b exp=0", lsu_misaligned); end
        checks++; if (mem_req !== 1'b0) begin failures++; $display("FAIL lb_req_done got=%b exp=0", mem_req); end
        @(negedge clk);   // back in IDLE
        checks++; if (lsu_done !== 1'b0) begin failures++; $display("FAIL lb_done_pulse got=%b exp=0", lsu_done); end
        checks++; if (lsu_ready !== 1'b1) begin failures++; $display("FAIL lb_ready got=%b exp=1", lsu_ready); end
        checks++; if (lsu_rdata !== 32'hFFFF_FF80) begin failures++; $display("FAIL lb_rdata_hold got=%h exp=ffffff80", lsu_rdata); end
    endtask

    task automatic test_store_half();
        send(1'b1, 32'h0000_0202, MEM_HALF, 1'b0, 32'h0000_BEEF);
        // A second request while busy must be ignored.
        lsu_valid = 1'b1;
        lsu_addr  = 32'h0000_0500;
        @(negedge clk);   // cycle 1, no grant
        checks++; if (mem_addr !== 32'h0000_0200) begin failures++; $display("FAIL sh_addr got=%h exp=00000200", mem_addr); end
        checks++; if (mem_be !== 4'b1100) begin failures++; $display("FAIL sh_be got=%b exp=1100", mem_be); end
        checks++; if (mem_wdata !== 32'hBEEF_0000) begin failures++; $display("FAIL sh_wdata got=%h exp=beef0000", mem_wdata); end
        checks++; if (mem_we !== 1'b1) begin failures++; $display("FAIL sh_we got=%b exp=1", mem_we); end
        @(negedge clk);   // cycle 2, still waiting
        checks++; if (mem_req !== 1'b1) begin failures++; $display("FAIL sh_req_wait got=%b exp=1", mem_req); end
        checks++; if (mem_addr !== 32'h0000_0200) begin failures++; $display("FAIL sh_addr_stable got=%h exp=00000200", mem_addr); end
        checks++; if (lsu_done !== 1'b0) begin failures++; $display("FAIL sh_done_early got=%b exp=0", lsu_done); end
        mem_gnt = 1'b1;
        @(negedge clk);   // cycle 3
        mem_gnt   = 1'b0;
        lsu_valid = 1'b0;
        checks++; if (lsu_done !== 1'b1) begin failures++; $display("FAIL sh_done got=%b exp=1", lsu_done); end
        checks++; if (lsu_rdata !== 32'h0) begin failures++; $display("FAIL sh_rdata got=%h exp=0", lsu_rdata); end
        checks++; if (mem_req !== 1'b0) begin failures++; $display("FAIL sh_req_done got=%b exp=0", mem_req); end
        @(negedge clk);
        checks++; if (lsu_ready !== 1'b1) begin failures++; $display("FAIL sh_ready got=%b exp=1", lsu_ready); end
    endtask

    task automatic test_load_half();
        // Unsigned half at offset 2
        send(1'b0, 32'h0000_0002, MEM_HALF, 1'b0, 32'h0);
        @(negedge clk);
        checks++; if (mem_be !== 4'b1100) begin failures++; $display("FAIL lhu_be got=%b exp=1100", mem_be); end
        mem_gnt   = 1'b1;
        mem_rdata = 32'h8765_4321;
        @(negedge clk);
        mem_gnt = 1'b0;
        checks++; if (lsu_rdata !== 32'h0000_8765) begin failures++; $display("FAIL lhu_rdata got=%h exp=00008765", lsu_rdata); end
        // Signed half at offset 1 stays within the word
        send(1'b0, 32'h0000_0001, MEM_HALF, 1'b1, 32'h0);
        @(negedge clk);
        checks++; if (mem_be !== 4'b0110) begin failures++; $display("FAIL lhs_be got=%b exp=0110", mem_be); end
        mem_gnt   = 1'b1;
        mem_rdata = 32'h00F0_0D00;
        @(negedge clk);
        mem_gnt = 1'b0;
        checks++; if (lsu_rdata !== 32'hFFFF_F00D) begin failures++; $display("FAIL lhs_rdata got=%h exp=fffff00d", lsu_rdata); end
        checks++; if (lsu_done !== 1'b1) begin failures++; $display("FAIL lhs_done got=%b exp=1", lsu_done); end
    endtask

    task automatic test_misaligned_load();
        send(1'b0, 32'h0000_0301, MEM_WORD, 1'b0, 32'h0);
        @(negedge clk);   // cycle 1
`ifdef LSU_MISALIGNED_SPLIT_EN
        checks++; if (mem_addr !== 32'h0000_0300) begin failures++; $display("FAIL ml_addr1 got=%h exp=00000300", mem_addr); end
        checks++; if (mem_be !== 4'b1110) begin failures++; $display("FAIL ml_be1 got=%b exp=1110", mem_be); end
        mem_gnt   = 1'b1;
        mem_rdata = 32'h4433_2211;
        @(negedge clk);   // cycle 2
        checks++; if (mem_req !== 1'b1) begin failures++; $display("FAIL ml_req2 got=%b exp=1", mem_req); end
        checks++; if (mem_addr !== 32'h0000_0304) begin failures++; $display("FAIL ml_addr2 got=%h exp=00000304", mem_addr); end
        checks++; if (mem_be !== 4'b0001) begin failures++; $display("FAIL ml_be2 got=%b exp=0001", mem_be); end
        mem_rdata = 32'h8877_6655;
        @(negedge clk);   // cycle 3
        mem_gnt = 1'b0;
        checks++; if (lsu_done !== 1'b1) begin failures++; $display("FAIL ml_done got=%b exp=1", lsu_done); end
        checks++; if (lsu_rdata !== 32'h5544_3322) begin failures++; $display("FAIL ml_rdata got=%h exp=55443322", lsu_rdata); end
        checks++; if (lsu_misaligned !== 1'b0) begin failures++; $display("FAIL ml_mis got=%b exp=0", lsu_misaligned); end
`else
        checks++; if (mem_req !== 1'b0) begin failures++; $display("FAIL ml_req got=%b exp=0", mem_req); end
        checks++; if (lsu_done !== 1'b1) begin failures++; $display("FAIL ml_done got=%b exp=1", lsu_done); end
        checks++; if (lsu_misaligned !== 1'b1) begin failures++; $display("FAIL ml_mis got=%b exp=1", lsu_misaligned); end
        checks++; if (lsu_rdata !== 32'h0) begin failures++; $display("FAIL ml_rdata got=%h exp=0", lsu_rdata); end
        @(negedge clk);
        checks++; if (mem_req !== 1'b0) begin failures++; $display("FAIL ml_req_after got=%b exp=0", mem_req); end
        checks++; if (lsu_ready !== 1'b1) begin failures++; $display("FAIL ml_ready got=%b exp=1", lsu_ready); end
        checks++; if (lsu_misaligned !== 1'b1) begin failures++; $display("FAIL ml_mis_hold got=%b exp=1", lsu_misaligned); end
`endif
    endtask

    task automatic test_wrap_store();
        send(1'b1, 32'hFFFF_FFFE, MEM_WORD, 1'b0, 32'hAABB_CCDD);
        @(negedge clk);   // cycle 1
`ifdef LSU_MISALIGNED_SPLIT_EN
        checks++; if (mem_addr !== 32'hFFFF_FFFC) begin failures++; $display("FAIL ws_addr1 got=%h exp=fffffffc", mem_addr); end
        checks++; if (mem_be !== 4'b1100) begin failures++; $display("FAIL ws_be1 got=%b exp=1100", mem_be); end
        checks++; if (mem_wdata !== 32'hCCDD_0000) begin failures++; $display("FAIL ws_wdata1 got=%h exp=ccdd0000", mem_wdata); end
        mem_gnt = 1'b1;
        @(negedge clk);   // cycle 2
        checks++; if (mem_addr !== 32'h0000_0000) begin failures++; $display("FAIL ws_addr2 got=%h exp=00000000", mem_addr); end
        checks++; if (mem_be !== 4'b0011) begin failures++; $display("FAIL ws_be2 got=%b exp=0011", mem_be); end
        checks++; if (mem_wdata !== 32'h0000_AABB) begin failures++; $display("FAIL ws_wdata2 got=%h exp=0000aabb", mem_wdata); end
        @(negedge clk);   // cycle 3
        mem_gnt = 1'b0;
        checks++; if (lsu_done !== 1'b1) begin failures++; $display("FAIL ws_done got=%b exp=1", lsu_done); end
        checks++; if (lsu_rdata !== 32'h0) begin failures++; $display("FAIL ws_rdata got=%h exp=0", lsu_rdata); end
`else
        checks++; if (mem_req !== 1'b0) begin failures++; $display("FAIL ws_req got=%b exp=0", mem_req); end
        checks++; if (lsu_done !== 1'b1) begin failures++; $display("FAIL ws_done got=%b exp=1", lsu_done); end
        checks++; if (lsu_misaligned !== 1'b1) begin failures++; $display("FAIL ws_mis got=%b exp=1", lsu_misaligned); end
`endif
        @(negedge clk);
        checks++; if (lsu_ready !== 1'b1) begin failures++; $display("FAIL ws_ready got=%b exp=1", lsu_ready); end
    endtask

    task automatic test_reset_mid();
        send(1'b0, 32'h0000_0600, MEM_WORD, 1'b0, 32'h0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++; if (mem_req !== 1'b1) begin failures++; $display("FAIL rm_req_hold%0d got=%b exp=1", i, mem_req); end
        end
        #2 rst_n = 1'b0;
        #1;
        checks++; if (mem_req !== 1'b0) begin failures++; $display("FAIL rm_req_async got=%b exp=0", mem_req); end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checks++; if (lsu_done !== 1'b0) begin failures++; $display("FAIL rm_done%0d got=%b exp=0", i, lsu_done); end
            checks++; if (lsu_ready !== 1'b1) begin failures++; $display("FAIL rm_ready%0d got=%b exp=1", i, lsu_ready); end
        end
    endtask

    // Scenario sequence
    initial begin
        checks     = 0;
        failures   = 0;
        rst_n      = 1'b1;
        lsu_valid  = 1'b0;
        lsu_we     = 1'b0;
        lsu_addr   = 32'h0;
        lsu_width  = MEM_BYTE;
        lsu_signed = 1'b0;
        lsu_wdata  = 32'h0;
        mem_gnt    = 1'b0;
        mem_rdata  = 32'h0;

        test_reset();
        test_load_byte();
        test_store_half();
        test_load_half();
        test_misaligned_load();
        test_wrap_store();
        test_reset_mid();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
